div_iter: RTL and testbench

- Iterative restoring divider, one quotient bit per cycle, for RV32M DIV/DIVU/REM/REMU.
- Sits beside the combinational ALU; the issue stage feeds it operands and the writeback mux consumes its result.
- Each iteration performs a trial subtraction and uses the borrow (carry) as the restore decision.
- Single in-flight operation; valid/ready handshakes on both sides.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 26 ++
 rtl/div_iter.sv | 143 ++++++++++++++
 tb/tb_div_iter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider (state encoding,
// signed-overflow dividend pattern, two's-complement negate).
package div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  // Widest operand the helpers support; callers size-cast down to N.
  localparam int unsigned MAX_W = 64;

  // Most-negative dividend; the top N bits give the pattern for width N.
  localparam logic [MAX_W-1:0] SIGNED_OVF_DIVIDEND = {1'b1, {(MAX_W-1){1'b0}}};

  function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude and keep the difference only when no borrow occurs.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   i_r,
  input  logic [N-1:0] i_b_abs,
  input  logic         i_bit,
  output logic [N:0]   o_r,
  output logic         o_q_bit
);

  logic [N+1:0] w_r_shift;
  logic [N+1:0] w_trial;
  logic         w_borrow;

  // One extra bit above the N+1-bit remainder turns the sign of the
  // difference into an explicit borrow flag.
  assign w_r_shift = {i_r, i_bit};
  assign w_trial   = w_r_shift - {2'b00, i_b_abs};
  assign w_borrow  = w_trial[N+1];

  assign o_r     = w_borrow ? w_r_shift[N:0] : w_trial[N:0];
  assign o_q_bit = ~w_borrow;

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_ITER_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module div_iter
  import div_pkg::*;
#(
  parameter int N = 32  // 2 <= N <= MAX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);

  state_t             r_state;
  logic               r_in_ready, r_busy, r_out_valid;
  logic               r_signed, r_q_neg, r_r_neg, r_div_zero, r_ovf;
  logic [N-1:0]       r_a, r_b, r_dvd, r_b_abs, r_q;
  logic [N:0]         r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_quotient, r_remainder;

  logic [N-1:0]       w_a_abs, w_b_abs, w_q_final, w_r_final;
  logic               w_div_zero, w_ovf, w_q_bit;
  logic [N:0]         w_r_next;

  assign w_a_abs    = (r_signed && r_a[N-1]) ? N'(neg(MAX_W'(r_a))) : r_a;
  assign w_b_abs    = (r_signed && r_b[N-1]) ? N'(neg(MAX_W'(r_b))) : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = r_signed && (r_a == SIGNED_OVF_DIVIDEND[MAX_W-1 -: N]) && (r_b == '1);

  div_step #(.N(N)) u_step (
    .i_r     (r_rem),
    .i_b_abs (r_b_abs),
    .i_bit   (r_dvd[N-1]),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  // Exceptional cases override the magnitude result; r_a still holds the original dividend.
  assign w_q_final = r_div_zero ? '1 :
                     r_ovf      ? r_a :
                     r_q_neg    ? N'(neg(MAX_W'(r_q))) : r_q;
  assign w_r_final = r_div_zero ? r_a :
                     r_ovf      ? '0 :
                     r_r_neg    ? N'(neg(MAX_W'(r_rem[N-1:0]))) : r_rem[N-1:0];

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_signed    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_dvd       <= '0;
      r_b_abs     <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_signed   <= op_signed;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= PREP;
          end
        end
        PREP: begin
          r_dvd      <= w_a_abs;
          r_b_abs    <= w_b_abs;
          r_q_neg    <= r_signed && (r_a[N-1] ^ r_b[N-1]);
          r_r_neg    <= r_signed && r_a[N-1];
          r_div_zero <= w_div_zero;
          r_ovf      <= w_ovf;
          r_rem      <= '0;
          r_q        <= '0;
          r_cnt      <= CNT_W'(N - 1);
`ifdef DIV_ITER_EARLY_OUT_EN
          r_state    <= (w_div_zero || w_ovf) ? FIX : CALC;
`else
          r_state    <= CALC;
`endif
        end
        CALC: begin
          r_rem <= w_r_next;
          r_q   <= {r_q[N-2:0], w_q_bit};
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          r_quotient  <= w_q_final;
          r_remainder <= w_r_final;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: arithmetic cases, exceptional
// operands, latency, output backpressure and mid-operation reset.
module tb_div_iter;

  localparam int N       = 32;
  localparam int LAT     = N + 2;
`ifdef DIV_ITER_EARLY_OUT_EN
  localparam int LAT_EXC = 2;
`else
  localparam int LAT_EXC = N + 2;
`endif
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, op_signed;
  logic [N-1:0] a, b;
  logic         out_valid, out_ready;
  logic [N-1:0] quotient, remainder;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_iter #(.N(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called #1 after an edge with the block idle; returns #1 after the accepting edge.
  task automatic start_op(input string tag, input logic sgn, input logic [N-1:0] aa,
                          input logic [N-1:0] bb);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    op_signed = sgn;
    a         = aa;
    b         = bb;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, "_busy"}, {busy, in_ready}, 2'b10);
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [N-1:0] aa,
                        input logic [N-1:0] bb, input logic [N-1:0] eq,
                        input logic [N-1:0] er, input int elat);
    int lat;
    out_ready = 1'b1;
    start_op(tag, sgn, aa, bb);
    wait_valid(tag, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    @(posedge clk); #1;
    check({tag, "_idle"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; op_signed = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ctrl", {in_ready, busy, out_valid}, 3'b100);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);

    run_op("u100_7",   1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        LAT);
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
    run_op("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        LAT);
    run_op("u_max_msb",1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,        32'h7FFF_FFFF, LAT);
    run_op("u_msb_max",1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, LAT);
    run_op("s_div0",   1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        LAT_EXC);
    run_op("u_div0",   1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        LAT_EXC);
    run_op("s_m5_div0",1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_EXC);
    run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        LAT_EXC);

    // Backpressure: result must hold while out_ready is low; in_valid is ignored.
    out_ready = 1'b0;
    start_op("bp", 1'b0, 32'd1000, 32'd10);
    wait_valid("bp", lat);
    check("bp_lat", lat, LAT);
    check("bp_q", quotient, 100);
    check("bp_r", remainder, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 32'(i + 1); b = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_hold_ctrl", {out_valid, in_ready, busy}, 3'b101);
      check("bp_hold_q", quotient, 100);
      check("bp_hold_r", remainder, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept", {out_valid, in_ready, busy}, 3'b010);
    check("bp_keep_q", quotient, 100);
    @(posedge clk); #1;
    check("bp_no_start", {in_ready, busy}, 2'b10);

    // Reset during CALC aborts the operation and clears the outputs.
    start_op("rst_mid", 1'b1, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ctrl", {in_ready, busy, out_valid}, 3'b100);
    check("rst_mid_q", quotient, 0);
    check("rst_mid_r", remainder, 0);
    run_op("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
